// File: rtl/ram_even_bist_if.sv
// RAM-side pin bundle between the even-address BIST initiator (master)
// and the 1 KB even-write RAM (slave).
interface ram_even_bist_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              mem_en;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_out;

  modport master (
    output mem_en, mem_wr, mem_rd, mem_addr, mem_a,
    input  mem_out
  );

  modport slave (
    input  mem_en, mem_wr, mem_rd, mem_addr, mem_a,
    output mem_out
  );
endinterface

// File: rtl/ram_even_bist.sv
// Self-test controller: writes a seeded pattern to every even RAM address,
// reads it back through a one-stage compare pipeline and reports the result.
module ram_even_bist #(
  parameter int              ADDR_W = 10,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  ram_even_bist_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(2);

  // Expected data for an even address: word index (addr >> 1) fitted to DATA_W, XOR SEED.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    logic [DATA_W-1:0] w;
    word = addr >> 1;
    w    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < ADDR_W) begin
        w[i] = word[i];
      end else begin
        w[i] = 1'b0;
      end
    end
    return w ^ SEED;
  endfunction

  state_t            state_q, state_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_a_q, mem_a_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ADDR_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pv_q, pv_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [DATA_W-1:0] pe_q, pe_d;

  // Next-state, registered-output and compare logic.
  always_comb begin
    state_d    = state_q;
    mem_en_d   = 1'b0;
    mem_wr_d   = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_a_d    = '0;
    busy_d     = 1'b0;
    done_d     = done_q;
    pass_d     = pass_q;
    err_d      = err_q;
    first_d    = first_q;
    pv_d       = 1'b0;
    pa_d       = pa_q;
    pe_d       = pe_q;

    // err_q still zero means this is the first mismatch of the run.
    if (pv_q && (mem.mem_out != pe_q)) begin
      if (err_q != {ADDR_W{1'b1}}) begin
        err_d = err_q + ADDR_W'(1);
      end else begin
        err_d = err_q;
      end
      if (err_q == '0) begin
        first_d = pa_q;
      end else begin
        first_d = first_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_WRITE;
          err_d      = '0;
          first_d    = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          mem_addr_d = '0;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_a_d    = pattern('0);
          busy_d     = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        busy_d = 1'b1;
        if (mem_addr_q == LAST_ADDR) begin
          state_d    = S_READ;
          mem_addr_d = '0;
          mem_en_d   = 1'b1;
          mem_rd_d   = 1'b1;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_STEP;
          mem_en_d   = 1'b1;
          mem_wr_d   = 1'b1;
          mem_a_d    = pattern(mem_addr_q + ADDR_STEP);
        end
      end
      S_READ: begin
        busy_d = 1'b1;
        pv_d   = 1'b1;
        pa_d   = mem_addr_q;
        pe_d   = pattern(mem_addr_q);
        if (mem_addr_q == LAST_ADDR) begin
          state_d    = S_DRAIN;
          mem_addr_d = '0;
        end else begin
          mem_addr_d = mem_addr_q + ADDR_STEP;
          mem_en_d   = 1'b1;
          mem_rd_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, output and compare-pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_a_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
      pv_q       <= 1'b0;
      pa_q       <= '0;
      pe_q       <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      mem_a_q    <= mem_a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      first_q    <= first_d;
      pv_q       <= pv_d;
      pa_q       <= pa_d;
      pe_q       <= pe_d;
    end
  end

  assign mem.mem_en      = mem_en_q;
  assign mem.mem_wr      = mem_wr_q;
  assign mem.mem_rd      = mem_rd_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_a       = mem_a_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_addr  = first_q;

endmodule

// File: tb/tb_ram_even_bist.sv
// Bench for ram_even_bist: behavioural RAM with injectable read faults,
// a cycle-indexed expectation model and directed scenarios.
module tb_ram_even_bist;
  localparam int        AW   = 10;
  localparam int        DW   = 8;
  localparam logic [7:0] SEED = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] err_cnt, first_err_addr;

  ram_even_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  ram_even_bist #(.ADDR_W(AW), .DATA_W(DW), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mem(mem_if),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   fault_mode = 0;
  int   exp_err = 0;
  int   exp_first = 0;
  int   exp_pass = 0;
  bit   tracking = 1'b0;
  int   k = 0;
  logic [7:0] ram [0:1023];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a >> 1) ^ SEED;
  endfunction

  function automatic logic [7:0] fault_data(input int a, input logic [7:0] d);
    case (fault_mode)
      1: return (a == 'h010) ? (d ^ 8'h01) : d;
      2: return d & 8'h7F;
      default: return d;
    endcase
  endfunction

  // Expected outcome: walk every even address, compare pattern against faulted read.
  task automatic set_model(input int fm);
    logic [7:0] p;
    fault_mode = fm;
    exp_err = 0;
    exp_first = 0;
    for (int a = 0; a < 1024; a += 2) begin
      p = pat(a);
      if (fault_data(a, p) != p) begin
        if (exp_err == 0) exp_first = a;
        if (exp_err < 1023) exp_err++;
      end
    end
    exp_pass = (exp_err == 0) ? 1 : 0;
  endtask

  // Behavioural RAM: even-address writes only, registered read with fault injection.
  always @(posedge clk) begin
    if (mem_if.mem_en && mem_if.mem_wr && !mem_if.mem_addr[0])
      ram[mem_if.mem_addr] <= mem_if.mem_a;
    if (mem_if.mem_en && mem_if.mem_rd)
      mem_if.mem_out <= fault_data(int'(mem_if.mem_addr), ram[mem_if.mem_addr]);
  end

  // Run position: k = edges since the accepted start; acceptance only when idle or done.
  always @(posedge clk) begin
    if (!rst) begin
      tracking <= 1'b0;
    end else if (start && (!tracking || k >= 1025)) begin
      tracking <= 1'b1;
      k <= 0;
    end else if (tracking) begin
      k <= k + 1;
    end
  end

  // Per-cycle comparison against the run-position model.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("wr_rd_exclusive", int'(mem_if.mem_wr && mem_if.mem_rd), 0);
      if (mem_if.mem_wr) chk("wr_even_addr", int'(mem_if.mem_addr[0]), 0);
      if (!tracking) begin
        chk("idle_ctl", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd, busy}), 0);
      end else if (k < 512) begin
        chk("write_ctl", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd, busy, done}), 'b11010);
        chk("write_addr", int'(mem_if.mem_addr), 2 * k);
        chk("write_data", int'(mem_if.mem_a), int'(pat(2 * k)));
        chk("err_cleared", int'(err_cnt), 0);
      end else if (k < 1024) begin
        chk("read_ctl", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd, busy, done}), 'b10110);
        chk("read_addr", int'(mem_if.mem_addr), 2 * (k - 512));
      end else if (k == 1024) begin
        chk("drain_ctl", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd, busy, done}), 'b00010);
      end else begin
        chk("done_ctl", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd, busy, done}), 'b00001);
        chk("done_pass", int'(pass), exp_pass);
        chk("done_err_cnt", int'(err_cnt), exp_err);
        chk("done_first_err", int'(first_err_addr), exp_first);
      end
    end
  end

  // One full run; optionally pokes start while busy at the 0x200 write.
  task automatic run(input int fm, input bit poke_busy, output int cyc);
    @(negedge clk);
    start = 1'b1;
    set_model(fm);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    chk("accept_err_clear", int'(err_cnt), 0);
    chk("accept_done_clear", int'(done), 0);
    while (!done && cyc < 1100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) chk("pattern_at_004", int'({mem_if.mem_addr, mem_if.mem_a}), int'({10'h004, 8'hA7}));
      if (poke_busy && cyc == 256) begin
        chk("poke_addr_200", int'(mem_if.mem_addr), 'h200);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_edge", cyc, 1025);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    mem_if.mem_out = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_strobes", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd}), 0);
    chk("reset_status", int'({busy, done, pass}), 0);
    chk("reset_addr_data", int'({mem_if.mem_addr, mem_if.mem_a}), 0);
    chk("reset_err", int'({err_cnt, first_err_addr}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 1'b0, cyc);
    chk("clean_pass", int'(pass), 1);
    chk("clean_err", int'(err_cnt), 0);
    chk("clean_first", int'(first_err_addr), 0);

    run(1, 1'b1, cyc);
    chk("single_pass", int'(pass), 0);
    chk("single_err", int'(err_cnt), 1);
    chk("single_first", int'(first_err_addr), 'h010);

    run(0, 1'b1, cyc);
    chk("b2b_pass", int'(pass), 1);
    chk("b2b_err", int'(err_cnt), 0);

    run(2, 1'b0, cyc);
    chk("stuck_pass", int'(pass), 0);
    chk("stuck_err", int'(err_cnt), 256);
    chk("stuck_first", int'(first_err_addr), 0);

    @(negedge clk);
    start = 1'b1;
    set_model(0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 128) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_addr_100", int'(mem_if.mem_addr), 'h100);
    #2 rst = 1'b0;
    #1;
    chk("abort_strobes", int'({mem_if.mem_en, mem_if.mem_wr, mem_if.mem_rd}), 0);
    chk("abort_status", int'({busy, done}), 0);
    chk("abort_err", int'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_idle", int'({mem_if.mem_en, busy, done}), 0);

    run(0, 1'b0, cyc);
    chk("restart_pass", int'(pass), 1);
    chk("restart_err", int'(err_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
